// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter
//   Shares one 4-bit arithmetic / arithmetical-shift unit between two
//   requesters. A round-robin arbiter accepts one operation at a time,
//   drives the unit from registered operands, waits SETTLE_CYCLES edges,
//   captures the unit outputs and returns them, tagged with the requester
//   ID, over a valid/ready response channel.
//
// Ports
//   Clk, Rst                       clock, asynchronous active-high reset
//   Req{0,1}_Valid/_Ready          request handshake (Ready combinational)
//   Req{0,1}_A/_B/_Sel             request operands and operation select
//   Alu_A/_B/_Sel                  registered operands to the unit
//   Alu_Out/_Carry_Out/_Neg_Flag   unit results
//   Rsp_Valid/_Ready               response handshake
//   Rsp_Id/_Out/_Carry/_Neg        captured response
//   Busy                           high whenever the sequencer is not IDLE
module alu_op_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Req0_Valid,
    output logic       Req0_Ready,
    input  logic [3:0] Req0_A,
    input  logic [3:0] Req0_B,
    input  logic [4:0] Req0_Sel,
    input  logic       Req1_Valid,
    output logic       Req1_Ready,
    input  logic [3:0] Req1_A,
    input  logic [3:0] Req1_B,
    input  logic [4:0] Req1_Sel,
    output logic [3:0] Alu_A,
    output logic [3:0] Alu_B,
    output logic [4:0] Alu_Sel,
    input  logic [3:0] Alu_Out,
    input  logic       Alu_Carry_Out,
    input  logic       Alu_Neg_Flag,
    output logic       Rsp_Valid,
    input  logic       Rsp_Ready,
    output logic       Rsp_Id,
    output logic [3:0] Rsp_Out,
    output logic       Rsp_Carry,
    output logic       Rsp_Neg,
    output logic       Busy
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_op_arbiter: SETTLE_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESPOND
    } state_t;

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [4:0] alu_sel_q, alu_sel_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_id_q, rsp_id_d;
    logic [3:0] rsp_out_q, rsp_out_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic       rsp_neg_q, rsp_neg_d;

    logic idle;
    logic accept;
    logic winner;

    // Under contention the grant goes to the requester that did not win last.
    assign idle       = (state_q == IDLE);
    assign Req0_Ready = idle & Req0_Valid & (~Req1_Valid | last_grant_q);
    assign Req1_Ready = idle & Req1_Valid & (~Req0_Valid | ~last_grant_q);
    assign accept     = (Req0_Valid & Req0_Ready) | (Req1_Valid & Req1_Ready);
    assign winner     = Req1_Ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_out_d    = rsp_out_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_neg_d    = rsp_neg_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_a_d      = winner ? Req1_A   : Req0_A;
                    alu_b_d      = winner ? Req1_B   : Req0_B;
                    alu_sel_d    = winner ? Req1_Sel : Req0_Sel;
                    rsp_id_d     = winner;
                    last_grant_d = winner;
                    cnt_d        = 4'(SETTLE_CYCLES);
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_out_d   = Alu_Out;
                    rsp_carry_d = Alu_Carry_Out;
                    rsp_neg_d   = Alu_Neg_Flag;
                    rsp_valid_d = 1'b1;
                    state_d     = RESPOND;
                end
            end
            RESPOND: begin
                if (Rsp_Ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_out_q    <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_neg_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_out_q    <= rsp_out_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_neg_q    <= rsp_neg_d;
        end
    end

    assign Alu_A     = alu_a_q;
    assign Alu_B     = alu_b_q;
    assign Alu_Sel   = alu_sel_q;
    assign Rsp_Valid = rsp_valid_q;
    assign Rsp_Id    = rsp_id_q;
    assign Rsp_Out   = rsp_out_q;
    assign Rsp_Carry = rsp_carry_q;
    assign Rsp_Neg   = rsp_neg_q;
    assign Busy      = ~idle;

endmodule

// File: tb/tb_alu_op_arbiter.sv
module tb_alu_op_arbiter;

    localparam int S = 2;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;
    logic Rst;

    // DUT with SETTLE_CYCLES = 2
    logic       r0v, r0r, r1v, r1r;
    logic [3:0] r0a, r0b, r1a, r1b;
    logic [4:0] r0s, r1s;
    logic [3:0] alu_a, alu_b, alu_out;
    logic [4:0] alu_sel;
    logic       alu_c, alu_n;
    logic       rsp_v, rsp_r, rsp_id, rsp_c, rsp_n, busy;
    logic [3:0] rsp_out;

    // DUT with SETTLE_CYCLES = 15
    logic       f_r0v, f_r0r, f_r1v, f_r1r;
    logic [3:0] f_r0a, f_r0b, f_r1a, f_r1b;
    logic [4:0] f_r0s, f_r1s;
    logic [3:0] f_alu_a, f_alu_b, f_alu_out;
    logic [4:0] f_alu_sel;
    logic       f_alu_c, f_alu_n;
    logic       f_rsp_v, f_rsp_r, f_rsp_id, f_rsp_c, f_rsp_n, f_busy;
    logic [3:0] f_rsp_out;

    // Arithmetic-unit stubs
    assign alu_out   = alu_a ^ alu_b;
    assign alu_c     = alu_a[3] & alu_b[3];
    assign alu_n     = alu_sel[0];
    assign f_alu_out = f_alu_a ^ f_alu_b;
    assign f_alu_c   = f_alu_a[3] & f_alu_b[3];
    assign f_alu_n   = f_alu_sel[0];

    alu_op_arbiter #(.SETTLE_CYCLES(S)) u_dut (
        .Clk(Clk), .Rst(Rst),
        .Req0_Valid(r0v), .Req0_Ready(r0r), .Req0_A(r0a), .Req0_B(r0b), .Req0_Sel(r0s),
        .Req1_Valid(r1v), .Req1_Ready(r1r), .Req1_A(r1a), .Req1_B(r1b), .Req1_Sel(r1s),
        .Alu_A(alu_a), .Alu_B(alu_b), .Alu_Sel(alu_sel),
        .Alu_Out(alu_out), .Alu_Carry_Out(alu_c), .Alu_Neg_Flag(alu_n),
        .Rsp_Valid(rsp_v), .Rsp_Ready(rsp_r), .Rsp_Id(rsp_id), .Rsp_Out(rsp_out),
        .Rsp_Carry(rsp_c), .Rsp_Neg(rsp_n), .Busy(busy)
    );

    alu_op_arbiter #(.SETTLE_CYCLES(15)) u_dut15 (
        .Clk(Clk), .Rst(Rst),
        .Req0_Valid(f_r0v), .Req0_Ready(f_r0r), .Req0_A(f_r0a), .Req0_B(f_r0b), .Req0_Sel(f_r0s),
        .Req1_Valid(f_r1v), .Req1_Ready(f_r1r), .Req1_A(f_r1a), .Req1_B(f_r1b), .Req1_Sel(f_r1s),
        .Alu_A(f_alu_a), .Alu_B(f_alu_b), .Alu_Sel(f_alu_sel),
        .Alu_Out(f_alu_out), .Alu_Carry_Out(f_alu_c), .Alu_Neg_Flag(f_alu_n),
        .Rsp_Valid(f_rsp_v), .Rsp_Ready(f_rsp_r), .Rsp_Id(f_rsp_id), .Rsp_Out(f_rsp_out),
        .Rsp_Carry(f_rsp_c), .Rsp_Neg(f_rsp_n), .Busy(f_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_last;   // model of the last granted requester

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        r0v = 0; r1v = 0; r0a = 0; r0b = 0; r0s = 0; r1a = 0; r1b = 0; r1s = 0; rsp_r = 0;
        f_r0v = 0; f_r1v = 0; f_r0a = 0; f_r0b = 0; f_r0s = 0;
        f_r1a = 0; f_r1b = 0; f_r1s = 0; f_rsp_r = 0;
        tick();
        tick();
        Rst = 1'b0;
        exp_last = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({alu_a, alu_b, alu_sel, rsp_v, rsp_id, rsp_out, rsp_c, rsp_n, busy, r0r, r1r} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {alu_a, alu_b, alu_sel, rsp_v, rsp_id, rsp_out, rsp_c, rsp_n, busy, r0r, r1r});
        end
    endtask

    task automatic test_single();
        do_reset();
        r0v = 1; r0a = 4'hA; r0b = 4'hC; r0s = 5'b00001;
        #1;
        n_checks++;
        if ({r0r, r1r} !== 2'b10) begin n_fail++; $display("FAIL single_ready got=%b exp=10", {r0r, r1r}); end
        tick(); // edge 0
        r0v = 0;
        n_checks++;
        if ({alu_a, alu_b, alu_sel, busy, rsp_v} !== {4'hA, 4'hC, 5'b00001, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL single_accept got=%h/%h/%h busy=%b v=%b exp=a/c/01 busy=1 v=0",
                               alu_a, alu_b, alu_sel, busy, rsp_v);
        end
        tick(); // edge 1
        n_checks++;
        if ({rsp_v, busy} !== 2'b01) begin n_fail++; $display("FAIL single_edge1 got v,busy=%b exp=01", {rsp_v, busy}); end
        tick(); // edge 2
        n_checks++;
        if ({rsp_v, rsp_out, rsp_c, rsp_n, rsp_id, busy} !== {1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL single_rsp got v=%b out=%h c=%b n=%b id=%b busy=%b exp v=1 out=6 c=1 n=1 id=0 busy=1",
                               rsp_v, rsp_out, rsp_c, rsp_n, rsp_id, busy);
        end
        rsp_r = 1;
        tick();
        rsp_r = 0;
        n_checks++;
        if ({rsp_v, busy, rsp_out, rsp_c, rsp_n} !== {1'b0, 1'b0, 4'h6, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL single_handshake got v=%b busy=%b out=%h c=%b n=%b exp v=0 busy=0 out=6 c=1 n=1",
                               rsp_v, busy, rsp_out, rsp_c, rsp_n);
        end
    endtask

    task automatic test_contention();
        int grants = 0;
        int last_cyc = 0;
        bit both_high = 0;
        bit g;
        bit granted;
        do_reset();
        r0v = 1; r1v = 1; rsp_r = 1;
        r0a = 4'($urandom); r0b = 4'($urandom); r1a = 4'($urandom); r1b = 4'($urandom);
        #1;
        for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
            granted = 0;
            if (r0r && r1r) both_high = 1;
            if (r0r || r1r) begin
                g = r1r;
                n_checks++;
                if (g !== ~exp_last) begin n_fail++; $display("FAIL contention_order op=%0d got=%0d exp=%0d", grants, g, ~exp_last); end
                if (grants > 0) begin
                    n_checks++;
                    if (cyc - last_cyc != S + 2) begin
                        n_fail++; $display("FAIL contention_interval got=%0d exp=%0d", cyc - last_cyc, S + 2);
                    end
                end
                exp_last = g;
                last_cyc = cyc;
                grants++;
                granted = 1;
            end
            tick();
            if (granted) begin
                if (g) begin r1a = 4'($urandom); r1b = 4'($urandom); end
                else   begin r0a = 4'($urandom); r0b = 4'($urandom); end
                #1;
            end
        end
        n_checks++;
        if (grants != 4) begin n_fail++; $display("FAIL contention_count got=%0d exp=4", grants); end
        n_checks++;
        if (both_high) begin n_fail++; $display("FAIL contention_onehot got=both_ready exp=at_most_one"); end
        r0v = 0; r1v = 0; rsp_r = 0;
    endtask

    task automatic test_backpressure();
        int k = 0;
        do_reset();
        r0v = 1; r0a = 4'h9; r0b = 4'hB; r0s = 5'h04;
        #1;
        tick();
        r0v = 0;
        r1v = 1; r1a = 4'h7; r1b = 4'h2; r1s = 5'h03;
        while (!rsp_v && k < 20) begin tick(); k++; end
        n_checks++;
        if (k != S) begin n_fail++; $display("FAIL bp_latency got=%0d exp=%0d", k, S); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({rsp_v, rsp_id, rsp_out, rsp_c, rsp_n} !== {1'b1, 1'b0, 4'h2, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL bp_hold cyc=%0d got v=%b id=%b out=%h c=%b n=%b exp v=1 id=0 out=2 c=1 n=0",
                                   i, rsp_v, rsp_id, rsp_out, rsp_c, rsp_n);
            end
            n_checks++;
            if ({r0r, r1r} !== 2'b00) begin n_fail++; $display("FAIL bp_ready cyc=%0d got=%b exp=00", i, {r0r, r1r}); end
            tick();
        end
        rsp_r = 1;
        #1;
        tick();
        rsp_r = 0;
        n_checks++;
        if ({rsp_v, busy, r1r} !== 3'b001) begin
            n_fail++; $display("FAIL bp_release got v,busy,r1r=%b exp=001", {rsp_v, busy, r1r});
        end
        tick();
        r1v = 0;
        exp_last = 1;
        n_checks++;
        if ({busy, alu_a, alu_b, alu_sel} !== {1'b1, 4'h7, 4'h2, 5'h03}) begin
            n_fail++; $display("FAIL bp_next_accept got busy=%b %h/%h/%h exp busy=1 7/2/03", busy, alu_a, alu_b, alu_sel);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        do_reset();
        r0v = 1; r0a = 4'hF; r0b = 4'h1; r0s = 5'h1F;
        #1;
        tick();
        r0v = 0;
        tick();
        Rst = 1;
        #1;
        n_checks++;
        if ({alu_a, alu_b, alu_sel, rsp_v, rsp_id, rsp_out, rsp_c, rsp_n, busy} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs got=%h exp=0",
                               {alu_a, alu_b, alu_sel, rsp_v, rsp_id, rsp_out, rsp_c, rsp_n, busy});
        end
        tick();
        Rst = 0;
        exp_last = 1;
        for (int i = 0; i < 6; i++) begin
            if (rsp_v || busy) seen = 1;
            tick();
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL rstmid_no_rsp got=activity exp=idle"); end
        r0v = 1; r1v = 1;
        #1;
        n_checks++;
        if ({r0r, r1r} !== 2'b10) begin n_fail++; $display("FAIL rstmid_first_grant got=%b exp=10", {r0r, r1r}); end
        r0v = 0; r1v = 0;
        #1;
    endtask

    task automatic test_idle_hold();
        bit bad = 0;
        do_reset();
        r0v = 1; r0a = 4'h9; r0b = 4'h5; r0s = 5'h02; rsp_r = 1;
        #1;
        tick();
        r0v = 0;
        exp_last = 0;
        repeat (S + 1) tick();
        rsp_r = 0;
        for (int i = 0; i < 10; i++) begin
            if ({busy, alu_a, alu_b, alu_sel, rsp_v, rsp_id, rsp_out, rsp_c, rsp_n} !==
                {1'b0, 4'h9, 4'h5, 5'h02, 1'b0, 1'b0, 4'hC, 1'b0, 1'b0}) bad = 1;
            tick();
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL idle_hold got=changed exp=busy0 alu 9/5/02 rsp out=c c=0 n=0 id=0"); end
        r0v = 1; r1v = 1;
        #1;
        n_checks++;
        if ({r0r, r1r} !== {exp_last, ~exp_last}) begin
            n_fail++; $display("FAIL idle_last_grant got=%b exp=%b", {r0r, r1r}, {exp_last, ~exp_last});
        end
        r0v = 0; r1v = 0;
        #1;
    endtask

    task automatic test_random();
        bit         pend[2];
        logic [3:0] pa[2], pb[2];
        logic [4:0] ps[2];
        bit         w;
        bit         rdy_bad;
        int         lat;
        do_reset();
        pend[0] = 0; pend[1] = 0;
        for (int op = 0; op < 25; op++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1; pa[i] = 4'($urandom); pb[i] = 4'($urandom); ps[i] = 5'($urandom);
                end
            end
            if (!pend[0] && !pend[1]) begin
                w = 1'($urandom_range(0, 1));
                pend[w] = 1; pa[w] = 4'($urandom); pb[w] = 4'($urandom); ps[w] = 5'($urandom);
            end
            r0v = pend[0]; r0a = pa[0]; r0b = pb[0]; r0s = ps[0];
            r1v = pend[1]; r1a = pa[1]; r1b = pb[1]; r1s = ps[1];
            #1;
            w = (pend[0] && pend[1]) ? ~exp_last : pend[1];
            n_checks++;
            if ({r0r, r1r} !== {~w, w}) begin n_fail++; $display("FAIL rand_grant op=%0d got=%b exp=%b", op, {r0r, r1r}, {~w, w}); end
            tick();
            n_checks++;
            if ({alu_a, alu_b, alu_sel} !== {pa[w], pb[w], ps[w]}) begin
                n_fail++; $display("FAIL rand_operands op=%0d got=%h/%h/%h exp=%h/%h/%h",
                                   op, alu_a, alu_b, alu_sel, pa[w], pb[w], ps[w]);
            end
            pend[w] = 0;
            exp_last = w;
            r0v = pend[0]; r1v = pend[1];
            rdy_bad = 0;
            lat = 0;
            while (!rsp_v && lat < 20) begin
                #1;
                if (r0r || r1r) rdy_bad = 1;
                tick();
                lat++;
            end
            n_checks++;
            if (lat != S) begin n_fail++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", op, lat, S); end
            n_checks++;
            if ({rsp_id, rsp_out, rsp_c, rsp_n} !== {w, pa[w] ^ pb[w], pa[w][3] & pb[w][3], ps[w][0]}) begin
                n_fail++; $display("FAIL rand_rsp op=%0d got id=%b out=%h c=%b n=%b exp id=%b out=%h c=%b n=%b",
                                   op, rsp_id, rsp_out, rsp_c, rsp_n, w, pa[w] ^ pb[w], pa[w][3] & pb[w][3], ps[w][0]);
            end
            repeat ($urandom_range(0, 3)) begin
                tick();
                if (!rsp_v || r0r || r1r) rdy_bad = 1;
            end
            n_checks++;
            if (rdy_bad) begin n_fail++; $display("FAIL rand_busy_ready op=%0d got=ready_or_drop exp=no_ready", op); end
            rsp_r = 1;
            tick();
            rsp_r = 0;
            n_checks++;
            if ({rsp_v, busy} !== 2'b00) begin n_fail++; $display("FAIL rand_handshake op=%0d got=%b exp=00", op, {rsp_v, busy}); end
        end
        r0v = 0; r1v = 0;
    endtask

    task automatic test_settle15();
        int lat = 0;
        f_r0v = 1; f_r0a = 4'h3; f_r0b = 4'h5; f_r0s = 5'h00;
        #1;
        n_checks++;
        if (f_r0r !== 1'b1) begin n_fail++; $display("FAIL s15_ready got=%b exp=1", f_r0r); end
        tick();
        f_r0v = 0;
        while (!f_rsp_v && lat < 30) begin tick(); lat++; end
        n_checks++;
        if (lat != 15) begin n_fail++; $display("FAIL s15_latency got=%0d exp=15", lat); end
        n_checks++;
        if ({f_rsp_out, f_rsp_c, f_rsp_n, f_rsp_id} !== {4'h6, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL s15_rsp got out=%h c=%b n=%b id=%b exp out=6 c=0 n=0 id=0",
                               f_rsp_out, f_rsp_c, f_rsp_n, f_rsp_id);
        end
        f_rsp_r = 1;
        tick();
        f_rsp_r = 0;
        repeat (5) tick();
        n_checks++;
        if ({f_busy, f_alu_a, f_alu_b} !== {1'b0, 4'h3, 4'h5}) begin
            n_fail++; $display("FAIL s15_alu_hold got busy=%b %h/%h exp busy=0 3/5", f_busy, f_alu_a, f_alu_b);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_idle_hold();
        test_random();
        do_reset();
        test_settle15();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_arbiter.md
Name: alu_op_arbiter

Overview:
- Sequences and shares the 4-bit arithmetic / arithmetical-shift unit between two requesters.
- Arbitrates round-robin and drives the unit's A/B/Sel from registered operands.
- Waits a programmable settle time, then captures Out/Carry_Out/Negative_Sign_Flag.
- Returns the result with the requester ID over a valid/ready response channel with backpressure.

Parameters:
- SETTLE_CYCLES, 1, cycles between driving operands and capturing results; legal range 1..15.

Ports:
- Clk  input  1  clock; all state changes on the rising edge
- Rst  input  1  asynchronous, active-high reset
- Req0_Valid  input  1  requester 0 has an operation
- Req0_Ready  output  1  requester 0 operation accepted this cycle when high with Req0_Valid
- Req0_A, Req0_B  input  4 each  requester 0 operands
- Req0_Sel  input  5  requester 0 operation select
- Req1_Valid, Req1_Ready, Req1_A, Req1_B, Req1_Sel  (same widths)  requester 1 channel, identical rules
- Alu_A, Alu_B  output  4 each  registered operands to the arithmetic unit
- Alu_Sel  output  5  registered select to the arithmetic unit
- Alu_Out  input  4  unit result
- Alu_Carry_Out  input  1  unit carry
- Alu_Neg_Flag  input  1  unit negative-sign flag
- Rsp_Valid  output  1  response available
- Rsp_Ready  input  1  consumer accepts response
- Rsp_Id  output  1  requester that issued the operation
- Rsp_Out  output  4  captured result
- Rsp_Carry  output  1  captured carry
- Rsp_Neg  output  1  captured negative flag
- Busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset values:
  - State = IDLE; Last_Grant = 1, so requester 0 wins the first contention.
  - Alu_A, Alu_B, Alu_Sel = 0.
  - Rsp_Valid, Rsp_Id, Rsp_Out, Rsp_Carry, Rsp_Neg = 0.
  - Settle counter = 0; Busy = 0.
- States:
  - IDLE -> SETTLE on a request handshake.
  - SETTLE -> RESPOND when the settle count expires.
  - RESPOND -> IDLE on a response handshake.
- Arbitration (IDLE only, combinational ready):
  - One valid: that requester's Ready = 1.
  - Both valid: Ready goes to the requester opposite Last_Grant.
  - Outside IDLE both Ready = 0.
  - At most one Ready is high in any cycle.
  - Ready may depend on Valid; a requester must not withdraw Valid before its handshake.
- Accept edge (Valid & Ready):
  - Latch A/B/Sel of the winner into Alu_A/Alu_B/Alu_Sel.
  - Latch winner index into the Rsp_Id holding register and into Last_Grant.
  - Load counter with SETTLE_CYCLES; go to SETTLE.
- SETTLE:
  - Decrement the counter each edge.
  - On the edge where counter == 1, capture Alu_Out/Alu_Carry_Out/Alu_Neg_Flag into Rsp_Out/Rsp_Carry/Rsp_Neg, set Rsp_Valid = 1, go to RESPOND.
  - Capture therefore occurs SETTLE_CYCLES edges after the accept edge.
- RESPOND:
  - Rsp_* held stable while Rsp_Valid & !Rsp_Ready.
  - On the Rsp_Valid & Rsp_Ready edge: Rsp_Valid = 0, go to IDLE.
  - Rsp_Out/Carry/Neg/Id keep their last values after the handshake.
- Alu_A/B/Sel stay constant from the accept edge until the next accept, including through RESPOND and IDLE.
- Latency:
  - Request accept to Rsp_Valid rising = SETTLE_CYCLES edges.
  - Minimum issue interval = SETTLE_CYCLES + 2 cycles with Rsp_Ready tied high; no accept occurs in the response-handshake cycle.
- Counter width: 4 bits. Values outside 1..15 are illegal (elaboration check).
- Rst asserted mid-operation:
  - Immediate return to reset values; the in-flight operation is dropped and no response is produced.
  - Last_Grant returns to 1.
- Neither Valid high in IDLE: hold IDLE with Busy = 0; no register changes.
- Arbitration state changes only on an accept.

Test Plan:
- Test setup: bench drives Alu_* inputs from a stub with Out = A ^ B, Carry = A[3] & B[3], Neg = Sel[0]; SETTLE_CYCLES = 2 unless stated.
- Single request: Req0 A=4'hA, B=4'hC, Sel=5'b00001 at edge 0 -> Alu_A=A, Alu_B=C after edge 0; Rsp_Valid=1 after edge 2 with Out=4'h6, Carry=1, Neg=1, Id=0; Busy high from edge 0 until the response handshake.
- Contention fairness: both requesters always valid for 4 operations, Rsp_Ready=1 -> grant order 0,1,0,1; each Ready pulses exactly one cycle; never both high.
- Backpressure: Rsp_Ready=0 for 5 cycles after Rsp_Valid -> Rsp_* stable and Req0_Ready=Req1_Ready=0 throughout; after Rsp_Ready=1, IDLE next cycle and a pending Req1 is accepted one edge later.
- Reset mid-SETTLE: assert Rst one cycle after accept -> all outputs 0 immediately, no Rsp_Valid afterwards; after release, simultaneous requests grant requester 0 first.
- SETTLE_CYCLES=15: request A=4'h3, B=4'h5 -> Rsp_Valid rises exactly 15 edges after accept, Out=4'h6; Alu_A/B unchanged until the next accept.
- Idle hold: no Valid for 10 cycles -> Busy=0, Alu_* and Rsp_* unchanged, Last_Grant unchanged.
